dcache_direct_mapped: RTL and testbench
=======================================

// Module: dcache_direct_mapped
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate L1 data cache sitting directly downstream of the load/store unit.
//  It serves demand word reads (level-held request, done pulse), and one-cycle prefetch hints issued when an entry enters the LSQ.
//  It also serves committed stores from the ROB and talks to main memory over a single-outstanding word bus.
// PARAMETERS
//  ADDR_W      32  byte-address width
//  DATA_W      32  word width (4 bytes)
//  LINE_WORDS  4   words per line (power of 2, >=2)
//  SETS        16  number of sets (power of 2)
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous reset, active-high
//  pf_valid   in   1       prefetch hint pulse
//  pf_addr    in   ADDR_W  prefetch byte address
//  rd_valid   in   1       demand read request; held until rd_done
//  rd_addr    in   ADDR_W  demand read address, word aligned (bits[1:0] ignored)
//  rd_done    out  1       read data valid this cycle
//  rd_data    out  DATA_W  full aligned word
//  wr_valid   in   1       committed store request
//  wr_addr    in   ADDR_W  store address (bits[1:0] ignored)
//  wr_data    in   DATA_W  store data, byte-lane positioned
//  wr_mask    in   4       byte enables
//  wr_ready   out  1       store accepted this cycle
//  mem_req    out  1       memory request valid
//  mem_we     out  1       1=write, 0=read
//  mem_addr   out  ADDR_W  word-aligned memory address
//  mem_wdata  out  DATA_W  write data
//  mem_wmask  out  4       write byte enables
//  mem_ready  in   1       memory accepts request this cycle
//  mem_rvalid in   1       read response valid (in order, arbitrary latency)
//  mem_rdata  in   DATA_W  read response data
// BEHAVIOUR
//  Address split: offset = addr[log2(LINE_WORDS)+1:2], index = next log2(SETS) bits, tag = rest.
//  Reset: all valid bits 0; FSM=IDLE; pf_pend=0; outputs rd_done=0, wr_ready=0, mem_req=0, mem_we=0, addr/data/mask=0.
//  Hit: rd_done is combinational, in the same cycle, when rd_valid, valid[index], and the tag matches.
//       rd_data = data[index][offset]. A hit is served in any FSM state unless index == the refilling set.
//  FSM states: IDLE, RF_REQ (issue word read), RF_WAIT (await mem_rvalid), WR_REQ (store write-through).
//  IDLE priority (highest first): wr_valid -> WR_REQ; rd_valid miss -> RF_REQ for that line; pf_pend miss -> RF_REQ.
//  RF_REQ: mem_req=1, mem_we=0, mem_addr={tag,index,cnt,2'b00}. On mem_ready -> RF_WAIT.
//  RF_WAIT: on mem_rvalid, write the word into the line and cnt++.
//       If cnt == LINE_WORDS-1: set valid and tag, clear pf_pend if it was the source, go to IDLE. Otherwise go to RF_REQ.
//       valid[index] is cleared on entering RF_REQ at cnt=0, so a partial line is never hit.
//  Demand read of a missing line completes on the first IDLE cycle after its refill, as a normal hit.
//       Miss latency = LINE_WORDS*(req+mem latency)+1 cycles.
//  WR_REQ: mem_req=1, mem_we=1, mem_addr=wr_addr&~3, mem_wdata=wr_data, mem_wmask=wr_mask.
//       On mem_ready: wr_ready=1 (one pulse); if the line hits, merge the masked bytes into the cached word in the same edge; go to IDLE.
//       wr_ready is never asserted outside WR_REQ.
//  Prefetch: 1-entry pf_pend register. pf_valid loads it only if pf_pend is empty, the address misses, and the line is not the one refilling.
//       Otherwise the hint is dropped silently. pf_pend is cleared if a demand refill targets the same line (merge).
//  Simultaneous wr_valid+rd_valid miss in IDLE: the store goes first. A read hit in the same cycle is still served.
//  A store to the line being refilled waits (wr_ready=0) until IDLE; no store/refill race is possible.
//  Reset mid-refill: abort immediately, drop the pending memory response (mem_rvalid is ignored while FSM=IDLE after reset).
// STRUCTURE
//  Shared defines header: ADDR_W/DATA_W macros (Addr_Width, Data_Width), FSM state encodings, word-address mask.
//  One sub-module: dcache_tag_data_array (valid/tag/data storage, combinational read port, one line-word write port, byte-masked merge port).
//  Top: FSM, refill counter, pf_pend register, memory mux.
// TESTING
//  1. Reset, rd_addr=0x100, 4-cycle memory latency -> 4 mem reads 0x100..0x10C; rd_done on the cycle after the last rvalid; data = mem[0x100].
//  2. Reread 0x104 after T1 -> rd_done the same cycle as rd_valid, no mem_req.
//  3. wr 0x108 data 0xAABBCCDD mask 4'b0011 (line cached) -> one mem write with mask 0011; a later read of 0x108 returns the upper half of the old word with low half 0xCCDD.
//  4. wr 0x400 (not cached) -> mem write only; a read of 0x400 then misses and refills.
//  5. pf 0x200 then rd 0x200 after 2 cycles -> a single refill (4 mem reads, not 8); rd_done after it.
//  6. rst asserted in RF_WAIT at cnt=2 -> mem_req=0 next cycle; a late mem_rvalid is ignored; rd 0x100 misses again.

Source files
------------

// File: rtl/dcache_direct_mapped_pkg.sv
// Shared widths, address-split constants and FSM state encoding for the direct-mapped L1 data cache.
package dcache_direct_mapped_pkg;

  localparam int unsigned Addr_Width = 32;
  localparam int unsigned Data_Width = 32;
  localparam int unsigned BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RF_REQ  = 2'd1,
    ST_RF_WAIT = 2'd2,
    ST_WR_REQ  = 2'd3
  } state_e;

endpackage

// File: rtl/dcache_tag_data_array.sv
// Valid/tag/data storage: three combinational lookup ports, one refill word-write port and one byte-masked merge port.
module dcache_tag_data_array
  import dcache_direct_mapped_pkg::*;
#(
  parameter int unsigned DATA_W = Data_Width,
  parameter int unsigned TAG_W  = 26,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned OFF_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    rd_idx_i,
  input  logic [OFF_W-1:0]    rd_off_i,
  output logic                rd_vld_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [DATA_W-1:0]   rd_word_o,
  input  logic [IDX_W-1:0]    pf_idx_i,
  output logic                pf_vld_o,
  output logic [TAG_W-1:0]    pf_tag_o,
  input  logic [IDX_W-1:0]    wr_idx_i,
  output logic                wr_vld_o,
  output logic [TAG_W-1:0]    wr_tag_o,
  input  logic [IDX_W-1:0]    fill_idx_i,
  input  logic [OFF_W-1:0]    fill_off_i,
  input  logic                fill_we_i,
  input  logic [DATA_W-1:0]   fill_wdata_i,
  input  logic                inval_i,
  input  logic                set_i,
  input  logic [TAG_W-1:0]    set_tag_i,
  input  logic                merge_en_i,
  input  logic [OFF_W-1:0]    merge_off_i,
  input  logic [DATA_W-1:0]   merge_wdata_i,
  input  logic [DATA_W/8-1:0] merge_mask_i
);

  localparam int unsigned NSETS  = 1 << IDX_W;
  localparam int unsigned NWORDS = 1 << OFF_W;

  logic [NSETS-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [NSETS];
  logic [DATA_W-1:0] data_q [NSETS][NWORDS];

  assign rd_vld_o  = valid_q[rd_idx_i];
  assign rd_tag_o  = tag_q[rd_idx_i];
  assign rd_word_o = data_q[rd_idx_i][rd_off_i];
  assign pf_vld_o  = valid_q[pf_idx_i];
  assign pf_tag_o  = tag_q[pf_idx_i];
  assign wr_vld_o  = valid_q[wr_idx_i];
  assign wr_tag_o  = tag_q[wr_idx_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (inval_i) valid_q[fill_idx_i] <= 1'b0;
      if (set_i)   valid_q[fill_idx_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (set_i)     tag_q[fill_idx_i] <= set_tag_i;
    if (fill_we_i) data_q[fill_idx_i][fill_off_i] <= fill_wdata_i;
    if (merge_en_i) begin
      for (int b = 0; b < int'(DATA_W / 8); b++) begin
        if (merge_mask_i[b]) data_q[wr_idx_i][merge_off_i][8*b +: 8] <= merge_wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-through, no-write-allocate L1 D-cache: same-cycle read hits, word-by-word line refill,
// a one-entry prefetch hint buffer and store write-through over a single-outstanding memory bus.
module dcache_direct_mapped
  import dcache_direct_mapped_pkg::*;
#(
  parameter int unsigned ADDR_W     = Addr_Width,
  parameter int unsigned DATA_W     = Data_Width,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pf_valid,
  input  logic [ADDR_W-1:0]   pf_addr,
  input  logic                rd_valid,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_done,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                wr_valid,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_mask,
  output logic                wr_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W - BYTE_OFF_W;
  localparam int unsigned LINE_W = TAG_W + IDX_W;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] rf_line_q, rf_line_d;
  logic              rf_src_pf_q, rf_src_pf_d;
  logic              pf_pend_q, pf_pend_d;
  logic [LINE_W-1:0] pf_line_q, pf_line_d;

  // Line address = {tag, index}; the index is its low IDX_W bits.
  logic [LINE_W-1:0] rd_line, pf_line, wr_line;
  logic [OFF_W-1:0]  rd_off, wr_off;
  assign rd_line = rd_addr[ADDR_W-1:OFF_W+BYTE_OFF_W];
  assign pf_line = pf_addr[ADDR_W-1:OFF_W+BYTE_OFF_W];
  assign wr_line = wr_addr[ADDR_W-1:OFF_W+BYTE_OFF_W];
  assign rd_off  = rd_addr[OFF_W+BYTE_OFF_W-1:BYTE_OFF_W];
  assign wr_off  = wr_addr[OFF_W+BYTE_OFF_W-1:BYTE_OFF_W];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[BYTE_OFF_W-1:0], wr_addr[BYTE_OFF_W-1:0],
                              pf_addr[OFF_W+BYTE_OFF_W-1:0]};

  logic              arr_rd_vld, arr_pf_vld, arr_wr_vld;
  logic [TAG_W-1:0]  arr_rd_tag, arr_pf_tag, arr_wr_tag;
  logic [DATA_W-1:0] arr_rd_word;
  logic              fill_we, inval, set_line, merge_en;

  dcache_tag_data_array #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .IDX_W  (IDX_W),
    .OFF_W  (OFF_W)
  ) u_array (
    .clk           (clk),
    .rst           (rst),
    .rd_idx_i      (rd_line[IDX_W-1:0]),
    .rd_off_i      (rd_off),
    .rd_vld_o      (arr_rd_vld),
    .rd_tag_o      (arr_rd_tag),
    .rd_word_o     (arr_rd_word),
    .pf_idx_i      (pf_line[IDX_W-1:0]),
    .pf_vld_o      (arr_pf_vld),
    .pf_tag_o      (arr_pf_tag),
    .wr_idx_i      (wr_line[IDX_W-1:0]),
    .wr_vld_o      (arr_wr_vld),
    .wr_tag_o      (arr_wr_tag),
    .fill_idx_i    (rf_line_d[IDX_W-1:0]),
    .fill_off_i    (cnt_q),
    .fill_we_i     (fill_we),
    .fill_wdata_i  (mem_rdata),
    .inval_i       (inval),
    .set_i         (set_line),
    .set_tag_i     (rf_line_q[LINE_W-1:IDX_W]),
    .merge_en_i    (merge_en),
    .merge_off_i   (wr_off),
    .merge_wdata_i (wr_data),
    .merge_mask_i  (wr_mask)
  );

  logic refilling, rd_hit, pf_hit, wr_hit, start_rd, pf_blocked;
  assign refilling = (state_q == ST_RF_REQ) || (state_q == ST_RF_WAIT);
  assign rd_hit = rd_valid && arr_rd_vld && (arr_rd_tag == rd_line[LINE_W-1:IDX_W]) &&
                  !(refilling && (rd_line[IDX_W-1:0] == rf_line_q[IDX_W-1:0]));
  assign pf_hit = arr_pf_vld && (arr_pf_tag == pf_line[LINE_W-1:IDX_W]);
  assign wr_hit = arr_wr_vld && (arr_wr_tag == wr_line[LINE_W-1:IDX_W]);

  assign rd_done = rd_hit;
  assign rd_data = rd_hit ? arr_rd_word : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rf_line_d   = rf_line_q;
    rf_src_pf_d = rf_src_pf_q;
    pf_pend_d   = pf_pend_q;
    pf_line_d   = pf_line_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wmask   = '0;
    wr_ready    = 1'b0;
    fill_we     = 1'b0;
    inval       = 1'b0;
    set_line    = 1'b0;
    merge_en    = 1'b0;
    start_rd    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_valid) begin
          state_d = ST_WR_REQ;
        end else if (rd_valid && !rd_hit) begin
          state_d     = ST_RF_REQ;
          cnt_d       = '0;
          rf_line_d   = rd_line;
          rf_src_pf_d = 1'b0;
          inval       = 1'b1;
          start_rd    = 1'b1;
          if (pf_pend_q && (pf_line_q == rd_line)) pf_pend_d = 1'b0;
        end else if (pf_pend_q) begin
          state_d     = ST_RF_REQ;
          cnt_d       = '0;
          rf_line_d   = pf_line_q;
          rf_src_pf_d = 1'b1;
          inval       = 1'b1;
        end
      end
      ST_RF_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {rf_line_q, cnt_q, {BYTE_OFF_W{1'b0}}};
        if (mem_ready) state_d = ST_RF_WAIT;
      end
      ST_RF_WAIT: begin
        if (mem_rvalid) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_OFF) begin
            set_line = 1'b1;
            state_d  = ST_IDLE;
            if (rf_src_pf_q) pf_pend_d = 1'b0;
          end else begin
            state_d = ST_RF_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        mem_req   = wr_valid;
        mem_we    = wr_valid;
        mem_addr  = {wr_addr[ADDR_W-1:BYTE_OFF_W], {BYTE_OFF_W{1'b0}}};
        mem_wdata = wr_data;
        mem_wmask = wr_mask;
        if (!wr_valid) begin
          state_d = ST_IDLE;
        end else if (mem_ready) begin
          wr_ready = 1'b1;
          merge_en = wr_hit;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A hint for the line already in flight (or starting now) is redundant and dropped.
    pf_blocked = (refilling && (pf_line == rf_line_q)) || (start_rd && (pf_line == rd_line));
    if (pf_valid && !pf_pend_q && !pf_hit && !pf_blocked) begin
      pf_pend_d = 1'b1;
      pf_line_d = pf_line;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rf_line_q   <= '0;
      rf_src_pf_q <= 1'b0;
      pf_pend_q   <= 1'b0;
      pf_line_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rf_line_q   <= rf_line_d;
      rf_src_pf_q <= rf_src_pf_d;
      pf_pend_q   <= pf_pend_d;
      pf_line_q   <= pf_line_d;
    end
  end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed bench for dcache_direct_mapped with a fixed-latency word memory model.
module tb_dcache_direct_mapped;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pf_valid;
  logic [31:0] pf_addr;
  logic        rd_valid;
  logic [31:0] rd_addr;
  logic        rd_done;
  logic [31:0] rd_data;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        wr_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = '0;

  always #5 clk = ~clk;

  dcache_direct_mapped dut (
    .clk        (clk),
    .rst        (rst),
    .pf_valid   (pf_valid),
    .pf_addr    (pf_addr),
    .rd_valid   (rd_valid),
    .rd_addr    (rd_addr),
    .rd_done    (rd_done),
    .rd_data    (rd_data),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_mask    (wr_mask),
    .wr_ready   (wr_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Memory: untouched words read as 0xA500_0000 | byte address; writes kept sparsely.
  logic [31:0] wmem [logic [31:0]];
  int          cyc = 0;
  int          resp_cnt = 0;
  logic [31:0] resp_addr;
  int          n_rd = 0;
  int          n_wr = 0;
  int          last_rv_cyc = -1;
  logic [31:0] rd_log [$];
  logic [31:0] last_waddr, last_wdata;
  logic [3:0]  last_wmask;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    return 32'hA500_0000 | a;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [31:0] w;
    mem_rvalid = 1'b0;
    if (resp_cnt == 1) begin
      mem_rvalid  = 1'b1;
      mem_rdata   = mem_word(resp_addr);
      last_rv_cyc = cyc;
    end
    if (resp_cnt > 0) resp_cnt--;
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        w = mem_word(mem_addr);
        for (int b = 0; b < 4; b++) if (mem_wmask[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        wmem[mem_addr] = w;
        n_wr++;
        last_waddr = mem_addr;
        last_wdata = mem_wdata;
        last_wmask = mem_wmask;
      end else begin
        resp_cnt  = LAT;
        resp_addr = mem_addr;
        n_rd++;
        rd_log.push_back(mem_addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, output logic [31:0] d,
                         output int start_c, output int done_c);
    bit ok = 1'b0;
    d = '0;
    done_c = -1;
    rd_addr  = a;
    rd_valid = 1'b1;
    start_c  = cyc;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (rd_done) begin
        d = rd_data;
        done_c = cyc;
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic wait_wr(input string tag);
    bit ok = 1'b0;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (wr_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m);
    wr_addr  = a;
    wr_data  = d;
    wr_mask  = m;
    wr_valid = 1'b1;
    wait_wr(tag);
  endtask

  initial begin
    logic [31:0] d;
    int sc, dc, r0, w0;

    rst = 1'b1; pf_valid = 1'b0; pf_addr = '0; rd_valid = 1'b0; rd_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0; mem_ready = 1'b1;
    tick(); tick();
    chk("rst_rd_done", {31'd0, rd_done}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: cold miss refills the whole line, finishing the cycle after the last response
    rd_log.delete(); r0 = n_rd;
    do_read("t1", 32'h100, d, sc, dc);
    chk("t1_nreads", n_rd - r0, 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_rd_addr", rd_log[i], 32'h100 + 32'(4 * i));
    chk("t1_data", d, 32'hA500_0100);
    chk("t1_done_cycle", dc, last_rv_cyc + 1);

    // 2: hit in the same cycle with no memory traffic
    r0 = n_rd;
    do_read("t2", 32'h104, d, sc, dc);
    chk("t2_latency", dc - sc, 32'd0);
    chk("t2_data", d, 32'hA500_0104);
    chk("t2_nreads", n_rd - r0, 32'd0);

    // 3: partial store to a cached word, with a read hit served alongside it
    w0 = n_wr; r0 = n_rd;
    wr_addr = 32'h108; wr_data = 32'hAABB_CCDD; wr_mask = 4'b0011; wr_valid = 1'b1;
    rd_addr = 32'h104; rd_valid = 1'b1;
    #1;
    chk("t3_rd_with_wr_done", {31'd0, rd_done}, 32'd1);
    chk("t3_rd_with_wr_data", rd_data, 32'hA500_0104);
    tick();
    rd_valid = 1'b0;
    wait_wr("t3");
    chk("t3_nwrites", n_wr - w0, 32'd1);
    chk("t3_waddr", last_waddr, 32'h108);
    chk("t3_wdata", last_wdata, 32'hAABB_CCDD);
    chk("t3_wmask", {28'd0, last_wmask}, 32'h3);
    do_read("t3r", 32'h108, d, sc, dc);
    chk("t3_merged", d, 32'hA500_CCDD);
    chk("t3_nreads", n_rd - r0, 32'd0);

    // 4: store to an uncached line goes to memory only; the later read refills
    w0 = n_wr; r0 = n_rd;
    do_write("t4", 32'h400, 32'h1122_3344, 4'hF);
    chk("t4_nwrites", n_wr - w0, 32'd1);
    chk("t4_no_alloc", n_rd - r0, 32'd0);
    rd_log.delete();
    do_read("t4r", 32'h400, d, sc, dc);
    chk("t4_nreads", n_rd - r0, 32'd4);
    chk("t4_first_addr", rd_log[0], 32'h400);
    chk("t4_data", d, 32'h1122_3344);

    // 5: prefetch then demand to the same line share one refill
    r0 = n_rd; rd_log.delete();
    pf_addr = 32'h200; pf_valid = 1'b1;
    tick();
    pf_valid = 1'b0;
    tick();
    do_read("t5", 32'h200, d, sc, dc);
    chk("t5_nreads", n_rd - r0, 32'd4);
    chk("t5_first_addr", rd_log[0], 32'h200);
    chk("t5_data", d, 32'hA500_0200);
    repeat (20) tick();
    chk("t5_no_extra", n_rd - r0, 32'd4);

    // 6: reset during RF_WAIT at cnt=2 aborts the refill; late response is dropped
    r0 = n_rd;
    rd_addr = 32'h100; rd_valid = 1'b1;
    for (int i = 0; i < 100 && (n_rd - r0) < 3; i++) tick();
    chk("t6_reached_cnt2", n_rd - r0, 32'd3);
    rst = 1'b1; rd_valid = 1'b0;
    tick();
    chk("t6_req_after_rst", {31'd0, mem_req}, 32'd0);
    rst = 1'b0;
    repeat (8) tick();
    chk("t6_resp_drained", resp_cnt, 32'd0);
    chk("t6_idle_no_req", n_rd - r0, 32'd3);
    r0 = n_rd; rd_log.delete();
    do_read("t6r", 32'h100, d, sc, dc);
    chk("t6_nreads", n_rd - r0, 32'd4);
    chk("t6_first_addr", rd_log[0], 32'h100);
    chk("t6_data", d, 32'hA500_0100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
